conway_engine: RTL and testbench



---
 rtl/conway_pkg.sv | 21 ++
 rtl/conway_cell.sv | 21 ++
 rtl/conway_engine.sv | 169 ++++++++++++++++
 tb/tb_conway_engine.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conway_pkg.sv
// Shared types and constants for the conway_engine Life-like cellular automaton.
package conway_pkg;

  // Controller states
  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2
  } state_e;

  // Common rule masks: bit k set = rule fires with k live neighbours
  localparam logic [8:0] RULE_B3      = 9'h008;
  localparam logic [8:0] RULE_S23     = 9'h00C;
  localparam logic [8:0] HIGHLIFE_B36 = 9'h048;

  // Row-major linear index of cell (r,c); the packed bit is N-1-idx
  function automatic int idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/conway_cell.sv
// Single-cell Life-like update: counts live neighbours and applies birth/survive masks.
module conway_cell (
  input  logic [7:0] nbrs,
  input  logic       self_bit,
  input  logic [8:0] birth_mask,
  input  logic [8:0] survive_mask,
  output logic       next_bit
);

  logic [3:0] n;

  // Neighbour population count and rule lookup
  always_comb begin
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + 4'(nbrs[i]);
    end
    next_bit = self_bit ? survive_mask[n] : birth_mask[n];
  end

endmodule

// File: rtl/conway_engine.sv
// ROWS x COLS Life-like automaton with run/pause/step control and generation counter.
// Optional macro CONWAY_STABLE_DETECT_EN: period-1/period-2 detection with auto-pause.
module conway_engine
  import conway_pkg::*;
#(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int WRAP    = 1,
  parameter int GEN_W   = 16,
  parameter int AUTORUN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 load,
  input  logic                 run,
  input  logic                 pause,
  input  logic                 step,
  input  logic [8:0]           birth_mask,
  input  logic [8:0]           survive_mask,
  output logic [ROWS*COLS-1:0] cells,
  output logic [GEN_W-1:0]     generation,
  output logic                 running,
  output logic                 extinct,
  output logic                 stable
);

  localparam int N = ROWS * COLS;

  logic [N-1:0]     cells_q, cells_d;
  logic [N-1:0]     next_grid;
  logic [GEN_W-1:0] gen_q, gen_d;
  state_e           state_q, state_d;
  logic             update;
  logic             stable_hit;

  // Neighbour wiring; out-of-grid taps read 0 when WRAP is off
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int RU  = (r == 0) ? ROWS - 1 : r - 1;
      localparam int RD  = (r == ROWS - 1) ? 0 : r + 1;
      localparam int CL  = (c == 0) ? COLS - 1 : c - 1;
      localparam int CR  = (c == COLS - 1) ? 0 : c + 1;
      localparam bit TE  = (WRAP == 0) && (r == 0);
      localparam bit BE  = (WRAP == 0) && (r == ROWS - 1);
      localparam bit LE  = (WRAP == 0) && (c == 0);
      localparam bit RE  = (WRAP == 0) && (c == COLS - 1);
      localparam int BIT = N - 1 - idx(r, c, COLS);

      logic [7:0] nb;
      assign nb[0] = (TE || LE) ? 1'b0 : cells_q[N-1-idx(RU, CL, COLS)];
      assign nb[1] = TE         ? 1'b0 : cells_q[N-1-idx(RU, c,  COLS)];
      assign nb[2] = (TE || RE) ? 1'b0 : cells_q[N-1-idx(RU, CR, COLS)];
      assign nb[3] = LE         ? 1'b0 : cells_q[N-1-idx(r,  CL, COLS)];
      assign nb[4] = RE         ? 1'b0 : cells_q[N-1-idx(r,  CR, COLS)];
      assign nb[5] = (BE || LE) ? 1'b0 : cells_q[N-1-idx(RD, CL, COLS)];
      assign nb[6] = BE         ? 1'b0 : cells_q[N-1-idx(RD, c,  COLS)];
      assign nb[7] = (BE || RE) ? 1'b0 : cells_q[N-1-idx(RD, CR, COLS)];

      conway_cell u_cell (
        .nbrs        (nb),
        .self_bit    (cells_q[BIT]),
        .birth_mask  (birth_mask),
        .survive_mask(survive_mask),
        .next_bit    (next_grid[BIT])
      );
    end
  end

  // A generation is computed in RUN and STEP unless a load takes the edge
  always_comb begin
    update = !load && ((state_q == RUN) || (state_q == STEP));
  end

  // Next-state logic: pause > run > step; load freezes the state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PAUSED: begin
        if (pause)     state_d = PAUSED;
        else if (run)  state_d = RUN;
        else if (step) state_d = STEP;
      end
      RUN: begin
        if (pause) state_d = PAUSED;
      end
      STEP: begin
        state_d = (run && !pause) ? RUN : PAUSED;
      end
      default: state_d = PAUSED;
    endcase
    if (stable_hit && (state_q == RUN)) state_d = PAUSED;
    if (load) state_d = state_q;
  end

  // Grid and generation counter next values
  always_comb begin
    cells_d = cells_q;
    gen_d   = gen_q;
    if (load) begin
      cells_d = seed;
      gen_d   = '0;
    end else if (update) begin
      cells_d = next_grid;
      gen_d   = gen_q + GEN_W'(1);
    end
  end

  // Core registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      cells_q <= seed;
      gen_q   <= '0;
      state_q <= (AUTORUN != 0) ? RUN : PAUSED;
    end else begin
      cells_q <= cells_d;
      gen_q   <= gen_d;
      state_q <= state_d;
    end
  end

`ifdef CONWAY_STABLE_DETECT_EN
  // prev_q is one generation behind cells_q, so next_grid==prev_q means period 2
  logic [N-1:0] prev_q, prev_d;
  logic [1:0]   age_q, age_d;
  logic         stable_q, stable_d;

  // History, generations-since-load age and stability flag next values
  always_comb begin
    prev_d     = prev_q;
    age_d      = age_q;
    stable_d   = stable_q;
    stable_hit = 1'b0;
    if (load) begin
      age_d    = '0;
      stable_d = 1'b0;
    end else if (update) begin
      prev_d     = cells_q;
      age_d      = (age_q == 2'd2) ? age_q : age_q + 2'd1;
      stable_hit = (age_q == 2'd2) && ((next_grid == cells_q) || (next_grid == prev_q));
      stable_d   = stable_hit;
    end
  end

  // History registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q   <= '0;
      age_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      age_q    <= age_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
`else
  assign stable_hit = 1'b0;
  assign stable     = 1'b0;
`endif

  assign cells      = cells_q;
  assign generation = gen_q;
  assign running    = (state_q == RUN);
  assign extinct    = (cells_q == '0);

endmodule

// File: tb/tb_conway_engine.sv
// Directed self-checking bench for conway_engine (several parameterisations).
module tb_conway_engine;
  import conway_pkg::*;

  logic clk;
  int   n_tests = 0;
  int   n_fail  = 0;

  // 16x16 torus, AUTORUN
  logic         w_rst = 1'b0, w_load = 1'b0, w_run = 1'b0, w_pause = 1'b0, w_step = 1'b0;
  logic [255:0] w_seed = '0, w_cells;
  logic [15:0]  w_gen;
  logic         w_running, w_extinct, w_stable;
  // 16x16 dead edge, 6-bit counter
  logic         d_rst = 1'b0;
  logic [255:0] d_seed = '0, d_cells;
  logic [5:0]   d_gen;
  logic         d_running, d_extinct, d_stable;
  // 16x16 torus, starts PAUSED
  logic         p_rst = 1'b0, p_run = 1'b0, p_step = 1'b0;
  logic [255:0] p_seed = '0, p_cells;
  logic [15:0]  p_gen;
  logic         p_running, p_extinct, p_stable;
  // 8x12 torus HighLife
  logic         h_rst = 1'b0;
  logic [95:0]  h_seed = '0, h_cells;
  logic [15:0]  h_gen;
  logic         h_running, h_extinct, h_stable;

  conway_engine #(.ROWS(16), .COLS(16), .WRAP(1), .GEN_W(16), .AUTORUN(1)) u_wrap (
    .clk(clk), .reset(w_rst), .seed(w_seed), .load(w_load), .run(w_run), .pause(w_pause),
    .step(w_step), .birth_mask(RULE_B3), .survive_mask(RULE_S23), .cells(w_cells),
    .generation(w_gen), .running(w_running), .extinct(w_extinct), .stable(w_stable));

  conway_engine #(.ROWS(16), .COLS(16), .WRAP(0), .GEN_W(6), .AUTORUN(1)) u_dead (
    .clk(clk), .reset(d_rst), .seed(d_seed), .load(1'b0), .run(1'b0), .pause(1'b0),
    .step(1'b0), .birth_mask(RULE_B3), .survive_mask(RULE_S23), .cells(d_cells),
    .generation(d_gen), .running(d_running), .extinct(d_extinct), .stable(d_stable));

  conway_engine #(.ROWS(16), .COLS(16), .WRAP(1), .GEN_W(16), .AUTORUN(0)) u_pause (
    .clk(clk), .reset(p_rst), .seed(p_seed), .load(1'b0), .run(p_run), .pause(1'b0),
    .step(p_step), .birth_mask(RULE_B3), .survive_mask(RULE_S23), .cells(p_cells),
    .generation(p_gen), .running(p_running), .extinct(p_extinct), .stable(p_stable));

  conway_engine #(.ROWS(8), .COLS(12), .WRAP(1), .GEN_W(16), .AUTORUN(1)) u_hl (
    .clk(clk), .reset(h_rst), .seed(h_seed), .load(1'b0), .run(1'b0), .pause(1'b0),
    .step(1'b0), .birth_mask(HIGHLIFE_B36), .survive_mask(RULE_S23), .cells(h_cells),
    .generation(h_gen), .running(h_running), .extinct(h_extinct), .stable(h_stable));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Set cell (r,c) in a grid of width cols and n cells
  function automatic logic [255:0] put(input logic [255:0] g, input int n, input int cols,
                                       input int r, input int c);
    logic [255:0] t;
    t = g;
    t[n-1-(r*cols+c)] = 1'b1;
    return t;
  endfunction

  // Phase-0 glider with its bounding box at (r0,c0) on a 16x16 grid
  function automatic logic [255:0] glider(input int r0, input int c0);
    logic [255:0] g;
    g = '0;
    g = put(g, 256, 16, r0,     c0 + 1);
    g = put(g, 256, 16, r0 + 1, c0 + 2);
    g = put(g, 256, 16, r0 + 2, c0);
    g = put(g, 256, 16, r0 + 2, c0 + 1);
    g = put(g, 256, 16, r0 + 2, c0 + 2);
    return g;
  endfunction

  // Reference generation step for an R x C grid
  function automatic logic [255:0] life_step(input logic [255:0] g, input int rr, input int cc,
                                             input bit wrap, input logic [8:0] bm,
                                             input logic [8:0] sm);
    logic [255:0] nx;
    int n, y, x, cnt;
    nx = '0;
    n  = rr * cc;
    for (int r = 0; r < rr; r++) begin
      for (int c = 0; c < cc; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              y = r + dr;
              x = c + dc;
              if (wrap) begin
                y = (y + rr) % rr;
                x = (x + cc) % cc;
                cnt += int'(g[n-1-(y*cc+x)]);
              end else if (y >= 0 && y < rr && x >= 0 && x < cc) begin
                cnt += int'(g[n-1-(y*cc+x)]);
              end
            end
          end
        end
        nx[n-1-(r*cc+c)] = g[n-1-(r*cc+c)] ? sm[cnt] : bm[cnt];
      end
    end
    return nx;
  endfunction

  logic [255:0] gl0, vert, horiz, blk, one, exp_g;
  logic [95:0]  hm;
  int           eg;

  initial begin
    gl0   = glider(0, 0);
    vert  = put(put(put('0, 256, 16, 7, 8), 256, 16, 8, 8), 256, 16, 9, 8);
    horiz = put(put(put('0, 256, 16, 8, 7), 256, 16, 8, 8), 256, 16, 8, 9);
    blk   = put(put(put(put('0, 256, 16, 14, 14), 256, 16, 14, 15), 256, 16, 15, 14), 256, 16, 15, 15);
    one   = put('0, 256, 16, 5, 5);

    // ---- torus glider ----
    @(negedge clk);
    w_seed = gl0;
    w_rst  = 1'b0;
    @(negedge clk);
    check("w_reset_cells", w_cells, gl0);
    check("w_reset_gen", w_gen, 0);
    check("w_reset_running", w_running, 1);
    check("w_reset_extinct", w_extinct, 0);
    check("w_reset_stable", w_stable, 0);
    w_rst = 1'b1;
    repeat (4) @(negedge clk);
    check("w_gen4", w_gen, 4);
    check("w_glider_shift", w_cells, glider(1, 1));
    repeat (60) @(negedge clk);
    check("w_gen64", w_gen, 64);
    check("w_wrap_home", w_cells, gl0);

    // pause still updates on its edge, then holds
    w_pause = 1'b1;
    @(negedge clk);
    w_pause = 1'b0;
    exp_g = life_step(gl0, 16, 16, 1'b1, RULE_B3, RULE_S23);
    check("w_pause_gen", w_gen, 65);
    check("w_pause_running", w_running, 0);
    check("w_pause_cells", w_cells, exp_g);
    repeat (3) @(negedge clk);
    check("w_hold_gen", w_gen, 65);
    check("w_hold_cells", w_cells, exp_g);
    w_run = 1'b1;
    @(negedge clk);
    w_run = 1'b0;
    check("w_run_gen", w_gen, 65);
    check("w_run_running", w_running, 1);
    w_step = 1'b1;
    @(negedge clk);
    w_step = 1'b0;
    check("w_step_in_run", w_gen, 66);
    @(negedge clk);
    check("w_step_ignored", w_gen, 67);
    check("w_step_ignored_run", w_running, 1);

    // ---- load and reset mid-run ----
    w_rst = 1'b0;
    @(negedge clk);
    w_rst = 1'b1;
    repeat (20) @(negedge clk);
    check("w_gen20", w_gen, 20);
    w_load = 1'b1;
    @(negedge clk);
    w_load = 1'b0;
    check("w_load_cells", w_cells, gl0);
    check("w_load_gen", w_gen, 0);
    check("w_load_running", w_running, 1);
    @(negedge clk);
    check("w_after_load_gen", w_gen, 1);
    repeat (5) @(negedge clk);
    w_rst = 1'b0;
    @(negedge clk);
    w_rst = 1'b1;
    check("w_rerst_cells", w_cells, gl0);
    check("w_rerst_gen", w_gen, 0);
    check("w_rerst_running", w_running, 1);

    // ---- blinker ----
    w_seed = vert;
    w_load = 1'b1;
    @(negedge clk);
    w_load = 1'b0;
    check("blk_load", w_cells, vert);
    for (int k = 1; k <= 6; k++) begin
`ifdef CONWAY_STABLE_DETECT_EN
      eg = (k > 3) ? 3 : k;
`else
      eg = k;
`endif
      @(negedge clk);
      check("blink_gen", w_gen, 16'(eg));
      check("blink_cells", w_cells, (eg % 2 == 1) ? horiz : vert);
`ifdef CONWAY_STABLE_DETECT_EN
      check("blink_stable", w_stable, (k >= 3) ? 1 : 0);
      check("blink_running", w_running, (k >= 3) ? 0 : 1);
`else
      check("blink_stable", w_stable, 0);
      check("blink_running", w_running, 1);
`endif
    end

    // ---- dead-edge glider settles into corner block ----
    d_seed = gl0;
    d_rst  = 1'b0;
    @(negedge clk);
    d_rst = 1'b1;
    check("d_reset_gen", d_gen, 0);
    repeat (52) @(negedge clk);
    check("d_gen52_glider", d_cells, glider(13, 13));
    repeat (8) @(negedge clk);
    check("d_gen60", d_gen, 60);
    check("d_block", d_cells, blk);
    check("d_not_extinct", d_extinct, 0);
    repeat (4) @(negedge clk);
    check("d_gen_wrap", d_gen, 0);
    check("d_block_kept", d_cells, blk);

    // ---- AUTORUN=0, single cell ----
    p_seed = one;
    p_rst  = 1'b0;
    @(negedge clk);
    p_rst = 1'b1;
    repeat (10) @(negedge clk);
    check("p_held_cells", p_cells, one);
    check("p_held_gen", p_gen, 0);
    check("p_held_running", p_running, 0);
    check("p_held_extinct", p_extinct, 0);
    p_step = 1'b1;
    @(negedge clk);
    p_step = 1'b0;
    check("p_step_pending", p_gen, 0);
    @(negedge clk);
    check("p_step_gen", p_gen, 1);
    check("p_step_cells", p_cells, 0);
    check("p_step_extinct", p_extinct, 1);
    check("p_step_running", p_running, 0);
    repeat (3) @(negedge clk);
    check("p_step_once", p_gen, 1);
    p_run  = 1'b1;
    p_step = 1'b1;
    @(negedge clk);
    p_run  = 1'b0;
    p_step = 1'b0;
    check("p_run_wins", p_running, 1);
    check("p_run_wins_gen", p_gen, 1);
    @(negedge clk);
    check("p_extinct_runs", p_gen, 2);
    check("p_extinct_stays", p_extinct, 1);

    // ---- HighLife 8x12 torus vs reference ----
    h_seed = {$urandom(), $urandom(), $urandom()};
    h_rst  = 1'b0;
    @(negedge clk);
    h_rst = 1'b1;
    hm = h_seed;
    check("h_reset_cells", h_cells, hm);
    for (int g = 1; g <= 100; g++) begin
      @(negedge clk);
      hm = 96'(life_step(256'(hm), 8, 12, 1'b1, HIGHLIFE_B36, RULE_S23));
      check("h_model", h_cells, hm);
    end
    check("h_gen100", h_gen, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
